// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, one bit per cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      fun_i,
    input  logic [XLEN-1:0] rs1_dai,
    input  logic [XLEN-1:0] rs2_dai,
    input  logic [4:0]      rd_adi,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_ado
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [2:0]      fun_q, fun_d;
    logic [4:0]      rd_q, rd_d;
    logic            sa_q, sa_d;
    logic            neg_q, neg_d;

    logic            is_div, sgn_a, sgn_b, sa, sb;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_sh, div_dif;
    logic [XLEN:0]     it_acc;
    logic [XLEN-1:0]   it_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;

    // Operand signedness, magnitudes and the divide corner cases
    always_comb begin
        is_div   = fun_i[2];
        sgn_a    = is_div ? ~fun_i[0] : (fun_i[1] ^ fun_i[0]);
        sgn_b    = is_div ? ~fun_i[0] : (fun_i[1:0] == 2'b01);
        sa       = sgn_a & rs1_dai[XLEN-1];
        sb       = sgn_b & rs2_dai[XLEN-1];
        mag_a    = sa ? -rs1_dai : rs1_dai;
        mag_b    = sb ? -rs2_dai : rs2_dai;
        div_zero = is_div & (rs2_dai == '0);
        div_ovf  = is_div & ~fun_i[0]
                 & (rs1_dai == {1'b1, {(XLEN-1){1'b0}}})
                 & (rs2_dai == '1);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = fun_i[1] ? rs1_dai : '1;
        end else begin
            fast_res = fun_i[1] ? '0 : rs1_dai;
        end
    end

    // One multiply or divide step plus the sign-corrected final result
    always_comb begin
        mul_sum = acc_q + {1'b0, (lo_q[0] ? opb_q : {XLEN{1'b0}})};
        div_sh  = {acc_q, lo_q[XLEN-1]};
        div_dif = div_sh - {2'b00, opb_q};
        if (fun_q[2]) begin
            if (div_dif[XLEN+1]) begin
                it_acc = div_sh[XLEN:0];
                it_lo  = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                it_acc = div_dif[XLEN:0];
                it_lo  = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            it_acc = {1'b0, mul_sum[XLEN:1]};
            it_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {it_acc[XLEN-1:0], it_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -it_lo : it_lo;
        rem_s  = sa_q ? -it_acc[XLEN-1:0] : it_acc[XLEN-1:0];
        case (fun_q)
            3'b000:  fin = prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  fin = prod_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  fin = quo_s;
            default: fin = rem_s;
        endcase
    end

    // Next-state and datapath register control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_d   = res_q;
        fun_d   = fun_q;
        rd_d    = rd_q;
        sa_d    = sa_q;
        neg_d   = neg_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        fun_d = fun_i;
                        rd_d  = rd_adi;
                        sa_d  = sa;
                        neg_d = sa ^ sb;
                        acc_d = '0;
                        cnt_d = '0;
                        lo_d  = is_div ? mag_a : mag_b;
                        opb_d = is_div ? mag_b : mag_a;
                        if (fast) begin
                            res_d   = fast_res;
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = it_acc;
                    lo_d  = it_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        res_d   = fin;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            fun_q   <= '0;
            rd_q    <= '0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            fun_q   <= fun_d;
            rd_q    <= rd_d;
            sa_q    <= sa_d;
            neg_q   <= neg_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE) & ~kill_i;
    assign stall_o  = ~kill_i & (((state_q == IDLE) & start_i)
                               | (state_q == BUSY));
    assign result_o = res_q;
    assign rd_ado   = rd_q;

endmodule
